rvh_l2_rd_responder: RTL

Memory-side responder for the L1D refill read channel. It accepts AR read-burst requests from the L1D MSHR banks and queues them. For each burst beat it issues a single-beat read to a backing memory port, then returns the data on the R channel with the original arid, rlast and rresp. It sits at the L2/memory end of the MEM NOC and is the counterpart of the MSHR AR initiator.

---
 rtl/rvh_l2_rd_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/rvh_l2_rd_responder.sv
// L2-side read responder: queues AR bursts, issues one backing-memory read per beat
// and returns in-order R beats tagged with the original id, rresp and rlast.
package rvh_l2_rd_responder_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic [ID_W-1:0]   arid;
        logic [ADDR_W-1:0] araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
    } cache_mem_if_ar_t;

    typedef struct packed {
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
    } cache_mem_if_r_t;
endpackage

module rvh_l2_rd_responder
    import rvh_l2_rd_responder_pkg::*;
#(
    parameter int AR_Q_DEPTH = 4,
    parameter int RBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              l2_req_if_arvalid,
    output logic              l2_req_if_arready,
    input  cache_mem_if_ar_t  l2_req_if_ar,
    output logic              l2_resp_if_rvalid,
    input  logic              l2_resp_if_rready,
    output cache_mem_if_r_t   l2_resp_if_r,
    output logic              mem_rd_req_valid_o,
    input  logic              mem_rd_req_ready_i,
    output logic [ADDR_W-1:0] mem_rd_req_addr_o,
    input  logic              mem_rd_resp_valid_i,
    input  logic [DATA_W-1:0] mem_rd_resp_data_i
);
    localparam int AQ_W = $clog2(AR_Q_DEPTH);
    localparam int RB_W = $clog2(RBUF_DEPTH);
    localparam int CR_W = RB_W + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            last;
        logic [1:0]      resp;
    } tag_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    // AR request queue
    cache_mem_if_ar_t  ar_q_mem [AR_Q_DEPTH];
    logic [AQ_W:0]     ar_wr_ptr_reg, ar_rd_ptr_reg;
    logic              ar_full, ar_empty, ar_push, ar_pop;
    cache_mem_if_ar_t  ar_head;

    assign ar_empty = (ar_wr_ptr_reg == ar_rd_ptr_reg);
    assign ar_full  = (ar_wr_ptr_reg[AQ_W] != ar_rd_ptr_reg[AQ_W]) &&
                      (ar_wr_ptr_reg[AQ_W-1:0] == ar_rd_ptr_reg[AQ_W-1:0]);
    assign l2_req_if_arready = ~ar_full;
    assign ar_push = l2_req_if_arvalid & ~ar_full;
    assign ar_head = ar_q_mem[ar_rd_ptr_reg[AQ_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_wr_ptr_reg <= '0;
            ar_rd_ptr_reg <= '0;
        end else begin
            if (ar_push) ar_wr_ptr_reg <= ar_wr_ptr_reg + 1'b1;
            if (ar_pop)  ar_rd_ptr_reg <= ar_rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_push) ar_q_mem[ar_wr_ptr_reg[AQ_W-1:0]] <= l2_req_if_ar;
    end

    // Issue FSM and active burst registers
    state_t            state_reg, state_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        len_reg, len_next;
    logic [2:0]        size_reg, size_next;
    logic [1:0]        burst_reg, burst_next;
    logic [7:0]        beat_cnt_reg, beat_cnt_next;
    logic [CR_W-1:0]   credit_reg;
    logic              mem_hs, r_hs;

    always_comb begin
        state_next         = state_reg;
        id_next            = id_reg;
        addr_next          = addr_reg;
        len_next           = len_reg;
        size_next          = size_reg;
        burst_next         = burst_reg;
        beat_cnt_next      = beat_cnt_reg;
        ar_pop             = 1'b0;
        mem_rd_req_valid_o = 1'b0;
        mem_hs             = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!ar_empty) begin
                    ar_pop        = 1'b1;
                    id_next       = ar_head.arid;
                    addr_next     = ar_head.araddr;
                    len_next      = ar_head.arlen;
                    size_next     = ar_head.arsize;
                    burst_next    = ar_head.arburst;
                    beat_cnt_next = 8'd0;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                mem_rd_req_valid_o = (credit_reg != '0);
                if (mem_rd_req_valid_o && mem_rd_req_ready_i) begin
                    mem_hs        = 1'b1;
                    // Only FIXED holds the address; error bursts walk like INCR.
                    if (burst_reg != 2'b00) addr_next = addr_reg + (ADDR_W'(1) << size_reg);
                    beat_cnt_next = beat_cnt_reg + 8'd1;
                    if (beat_cnt_reg == len_reg) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_rd_req_addr_o = (state_reg == ISSUE) ? addr_reg : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            id_reg       <= id_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            size_reg     <= size_next;
            burst_reg    <= burst_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Credits bound issued-but-not-returned beats to the data buffer size.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_reg <= CR_W'(RBUF_DEPTH);
        end else if (mem_hs && !r_hs) begin
            credit_reg <= credit_reg - CR_W'(1);
        end else if (!mem_hs && r_hs) begin
            credit_reg <= credit_reg + CR_W'(1);
        end
    end

    // Tag and data FIFOs share the R-handshake pop
    tag_t              tag_mem  [RBUF_DEPTH];
    logic [DATA_W-1:0] data_mem [RBUF_DEPTH];
    logic [RB_W:0]     tag_wr_ptr_reg, tag_rd_ptr_reg;
    logic [RB_W:0]     data_wr_ptr_reg, data_rd_ptr_reg;
    tag_t              tag_push_val, tag_head;
    logic              data_empty;

    assign tag_push_val.id   = id_reg;
    assign tag_push_val.last = (beat_cnt_reg == len_reg);
    assign tag_push_val.resp = burst_reg[1] ? 2'b10 : 2'b00;

    assign data_empty        = (data_wr_ptr_reg == data_rd_ptr_reg);
    assign l2_resp_if_rvalid = ~data_empty;
    assign r_hs              = l2_resp_if_rvalid & l2_resp_if_rready;
    assign tag_head          = tag_mem[tag_rd_ptr_reg[RB_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr_ptr_reg  <= '0;
            tag_rd_ptr_reg  <= '0;
            data_wr_ptr_reg <= '0;
            data_rd_ptr_reg <= '0;
        end else begin
            if (mem_hs)              tag_wr_ptr_reg  <= tag_wr_ptr_reg + 1'b1;
            if (mem_rd_resp_valid_i) data_wr_ptr_reg <= data_wr_ptr_reg + 1'b1;
            if (r_hs) begin
                tag_rd_ptr_reg  <= tag_rd_ptr_reg + 1'b1;
                data_rd_ptr_reg <= data_rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_hs)              tag_mem[tag_wr_ptr_reg[RB_W-1:0]]   <= tag_push_val;
        if (mem_rd_resp_valid_i) data_mem[data_wr_ptr_reg[RB_W-1:0]] <= mem_rd_resp_data_i;
    end

    always_comb begin
        l2_resp_if_r = '0;
        if (l2_resp_if_rvalid) begin
            l2_resp_if_r.rid   = tag_head.id;
            l2_resp_if_r.rdata = data_mem[data_rd_ptr_reg[RB_W-1:0]];
            l2_resp_if_r.rresp = tag_head.resp;
            l2_resp_if_r.rlast = tag_head.last;
        end
    end

`ifndef SYNTHESIS
    logic [CR_W-1:0] tag_cnt, data_cnt;
    assign tag_cnt  = tag_wr_ptr_reg - tag_rd_ptr_reg;
    assign data_cnt = data_wr_ptr_reg - data_rd_ptr_reg;

    a_no_data_overflow: assert property (@(posedge clk) disable iff (!rst)
        mem_rd_resp_valid_i |-> (data_cnt != CR_W'(RBUF_DEPTH)));
    a_rvalid_has_tag: assert property (@(posedge clk) disable iff (!rst)
        l2_resp_if_rvalid |-> (tag_cnt != '0));
    // Every tag without data is an outstanding read, so a response needs one.
    a_resp_not_exceed: assert property (@(posedge clk) disable iff (!rst)
        mem_rd_resp_valid_i |-> (tag_cnt > data_cnt));
`endif
endmodule
